// File: rtl/traffic_phase_sequencer.sv
// Traffic intersection phase sequencer: NS/EW green-yellow-all-red cycle with a
// latched pedestrian walk phase inserted after either all-red clearance.
module traffic_phase_sequencer #(
    parameter int NS_GREEN_S = 20,
    parameter int EW_GREEN_S = 15,
    parameter int YELLOW_S   = 3,
    parameter int ALL_RED_S  = 1,
    parameter int WALK_S     = 10
) (
    input  logic       clk,
    input  logic       Sync_Reset,
    input  logic       OneHz,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase,
    output logic [5:0] sec_left
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        PED_WALK  = 3'd6,
        ILLEGAL   = 3'd7
    } state_t;

    state_t     state, state_n;
    logic [5:0] sec_n;
    logic       pend_n;
    logic       next_dir, dir_n;
    logic       onehz_q;
    logic       tick;
    logic       entering_walk;

    function automatic logic [5:0] load_val(input state_t s);
        case (s)
            NS_GREEN:             load_val = 6'(NS_GREEN_S - 1);
            EW_GREEN:             load_val = 6'(EW_GREEN_S - 1);
            NS_YELLOW, EW_YELLOW: load_val = 6'(YELLOW_S - 1);
            PED_WALK:             load_val = 6'(WALK_S - 1);
            default:              load_val = 6'(ALL_RED_S - 1);
        endcase
    endfunction

    assign tick = OneHz & ~onehz_q;

    always_ff @(posedge clk or posedge Sync_Reset) begin
        if (Sync_Reset) begin
            state       <= ALL_RED_B;
            sec_left    <= 6'(ALL_RED_S - 1);
            ped_pending <= 1'b0;
            next_dir    <= 1'b0;
            // Held high so a OneHz level already high at release is not a tick.
            onehz_q     <= 1'b1;
        end else begin
            state       <= state_n;
            sec_left    <= sec_n;
            ped_pending <= pend_n;
            next_dir    <= dir_n;
            onehz_q     <= OneHz;
        end
    end

    always_comb begin
        state_n = state;
        sec_n   = sec_left;
        dir_n   = next_dir;
        if (state == ILLEGAL) begin
            state_n = ALL_RED_A;
            sec_n   = load_val(ALL_RED_A);
        end else if (tick) begin
            if (sec_left != 6'd0) begin
                sec_n = sec_left - 6'd1;
            end else begin
                case (state)
                    NS_GREEN:  state_n = NS_YELLOW;
                    NS_YELLOW: state_n = ALL_RED_A;
                    ALL_RED_A: begin
                        state_n = ped_pending ? PED_WALK : EW_GREEN;
                        if (ped_pending) dir_n = 1'b1;
                    end
                    EW_GREEN:  state_n = EW_YELLOW;
                    EW_YELLOW: state_n = ALL_RED_B;
                    ALL_RED_B: begin
                        state_n = ped_pending ? PED_WALK : NS_GREEN;
                        if (ped_pending) dir_n = 1'b0;
                    end
                    PED_WALK:  state_n = next_dir ? EW_GREEN : NS_GREEN;
                    default:   state_n = ALL_RED_A;
                endcase
                sec_n = load_val(state_n);
            end
        end
    end

    // Clearing on walk entry takes priority over a request in the same clk.
    always_comb begin
        entering_walk = (state_n == PED_WALK) && (state != PED_WALK);
        pend_n        = ped_pending;
        if (entering_walk) begin
            pend_n = 1'b0;
        end else if (ped_req && (state != PED_WALK)) begin
            pend_n = 1'b1;
        end
    end

    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        walk     = 1'b0;
        case (state)
            NS_GREEN:  ns_light = 3'b001;
            NS_YELLOW: ns_light = 3'b010;
            EW_GREEN:  ew_light = 3'b001;
            EW_YELLOW: ew_light = 3'b010;
            PED_WALK:  walk     = 1'b1;
            default:   ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: a phase-table reference model predicts each clk's outputs for a
// default-parameter instance and an all-ones instance driven by the same stimulus.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       Sync_Reset = 1'b1;
    logic       OneHz = 1'b1;
    logic       ped_req = 1'b0;

    logic [2:0] ns_d, ew_d, phase_d, ns_o, ew_o, phase_o;
    logic       walk_d, pend_d, walk_o, pend_o;
    logic [5:0] sec_d, sec_o;

    traffic_phase_sequencer dut_def (
        .clk(clk), .Sync_Reset(Sync_Reset), .OneHz(OneHz), .ped_req(ped_req),
        .ns_light(ns_d), .ew_light(ew_d), .walk(walk_d), .ped_pending(pend_d),
        .phase(phase_d), .sec_left(sec_d)
    );

    traffic_phase_sequencer #(
        .NS_GREEN_S(1), .EW_GREEN_S(1), .YELLOW_S(1), .ALL_RED_S(1), .WALK_S(1)
    ) dut_one (
        .clk(clk), .Sync_Reset(Sync_Reset), .OneHz(OneHz), .ped_req(ped_req),
        .ns_light(ns_o), .ew_light(ew_o), .walk(walk_o), .ped_pending(pend_o),
        .phase(phase_o), .sec_left(sec_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int sec;
        int ns;
        int ew;
        int wk;
        int pend;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int failed = 0;

    // Reference model: phase index, remaining seconds-minus-one, pending, direction.
    int durs[2][7];
    int mp[2], mr[2], mpend[2], mdir[2], mprev[2];
    bit [31:0] hz_cnt;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int ns_of(input int p);
        return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    endfunction

    function automatic int ew_of(input int p);
        return (p == 3) ? 1 : (p == 4) ? 2 : 4;
    endfunction

    task automatic model_step(input int k, input logic ohz, input logic pr, input logic rst);
        int  op;
        int  ope;
        int  np;
        bit  tk;
        bit  ent;
        if (rst) begin
            mp[k] = 5; mr[k] = durs[k][5] - 1; mpend[k] = 0; mdir[k] = 0; mprev[k] = 1;
            return;
        end
        op  = mp[k];
        ope = mpend[k];
        tk  = ohz && !mprev[k];
        ent = 0;
        mprev[k] = ohz;
        if (tk) begin
            if (mr[k] > 0) begin
                mr[k]--;
            end else begin
                case (op)
                    0: np = 1;
                    1: np = 2;
                    2: np = 3;
                    3: np = 4;
                    4: np = 5;
                    5: np = 0;
                    default: np = mdir[k] ? 3 : 0;
                endcase
                if ((op == 2 || op == 5) && ope != 0) begin
                    mdir[k] = (op == 2) ? 1 : 0;
                    np = 6;
                    ent = 1;
                end
                mp[k] = np;
                mr[k] = durs[k][np] - 1;
            end
        end
        if (ent) mpend[k] = 0;
        else if (pr && op != 6) mpend[k] = 1;
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.ph = mp[k]; e.sec = mr[k]; e.ns = ns_of(mp[k]); e.ew = ew_of(mp[k]);
        e.wk = (mp[k] == 6) ? 1 : 0; e.pend = mpend[k];
        return e;
    endfunction

    task automatic cycle(input logic ohz, input logic pr, input logic rst);
        bit rise;
        @(negedge clk);
        rise = rst && !Sync_Reset;
        OneHz = ohz;
        ped_req = pr;
        Sync_Reset = rst;
        for (int k = 0; k < 2; k++) model_step(k, ohz, pr, rst);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        if (rise) begin
            #1;
            chk("async_rst_phase", int'(phase_d), 5);
            chk("async_rst_sec", int'(sec_d), 0);
            chk("async_rst_walk", int'(walk_d), 0);
            chk("async_rst_pend", int'(pend_d), 0);
            chk("async_rst_ns", int'(ns_d), 4);
            chk("async_rst_ew", int'(ew_d), 4);
        end
    endtask

    task automatic step(input logic pr);
        hz_cnt++;
        cycle(hz_cnt[1], pr, 1'b0);
    endtask

    task automatic wait_phase(input int p, input logic pr);
        int n = 0;
        while (mp[0] != p && n < 4000) begin
            step(pr);
            n++;
        end
        chk("wait_phase_bound", (n < 4000) ? 1 : 0, 1);
    endtask

    // Monitor: every clk the DUTs present a fresh output set, checked against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("def_phase", int'(phase_d), e.ph);
                chk("def_sec", int'(sec_d), e.sec);
                chk("def_ns", int'(ns_d), e.ns);
                chk("def_ew", int'(ew_d), e.ew);
                chk("def_walk", int'(walk_d), e.wk);
                chk("def_pend", int'(pend_d), e.pend);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("one_phase", int'(phase_o), e.ph);
                chk("one_sec", int'(sec_o), e.sec);
                chk("one_ns", int'(ns_o), e.ns);
                chk("one_ew", int'(ew_o), e.ew);
                chk("one_walk", int'(walk_o), e.wk);
                chk("one_pend", int'(pend_o), e.pend);
            end
        end
    end

    initial begin
        int n;
        bit lvl;
        int hold;
        durs[0] = '{20, 3, 1, 15, 3, 1, 10};
        durs[1] = '{1, 1, 1, 1, 1, 1, 1};
        for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b0, 1'b1);

        // Reset held with OneHz high, released with OneHz still high.
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        hz_cnt = 2;

        // Two plain cycles without pedestrians.
        repeat (2 * 43 * 4 + 20) step(1'b0);

        // Single-clk request during NS green, walk inserted before EW green.
        wait_phase(0, 1'b0);
        step(1'b1);
        wait_phase(6, 1'b0);
        wait_phase(3, 1'b0);

        // Request held through the walk and into EW green.
        wait_phase(0, 1'b0);
        step(1'b1);
        wait_phase(6, 1'b0);
        wait_phase(3, 1'b1);
        repeat (8) step(1'b1);
        wait_phase(6, 1'b0);
        wait_phase(0, 1'b0);
        repeat (10) step(1'b0);

        // Reset asserted mid-walk at four seconds left.
        wait_phase(0, 1'b0);
        step(1'b1);
        wait_phase(6, 1'b0);
        n = 0;
        while (!(mp[0] == 6 && mr[0] == 4) && n < 200) begin
            step(1'b0);
            n++;
        end
        chk("walk_sec4_bound", (n < 200) ? 1 : 0, 1);
        cycle(hz_cnt[1], 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        hz_cnt = 2;
        repeat (20) step(1'b0);

        // Randomized OneHz jitter and sparse pedestrian presses.
        lvl = hz_cnt[1];
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                lvl = ~lvl;
                hold = $urandom_range(1, 3);
            end
            hold--;
            cycle(lvl, ($urandom_range(0, 59) == 0), 1'b0);
        end

        // OneHz frozen: nothing may move.
        repeat (1000) cycle(lvl, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
